// File: rtl/esop_cube_sequencer_pkg.sv
// Shared types and sizing for the ESOP cube sequencer.
// ESOP_MATCH_CNT_EN (optional) adds a per-result cube-hit counter.
package esop_pkg;

    localparam int unsigned NUM_VARS  = 10;
    localparam int unsigned MAX_CUBES = 128;
    localparam int unsigned CUBE_AW   = $clog2(MAX_CUBES);
    localparam int unsigned CNT_W     = CUBE_AW + 1;

    typedef struct packed {
        logic [NUM_VARS-1:0] mask;
        logic [NUM_VARS-1:0] pol;
    } cube_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/esop_cube_sequencer_if.sv
// Config, input-vector and result bus of the ESOP cube sequencer.
// ESOP_MATCH_CNT_EN adds out_match_cnt.
interface esop_cube_sequencer_if;
    import esop_pkg::*;

    logic                cfg_we;
    logic [CUBE_AW-1:0]  cfg_addr;
    logic [NUM_VARS-1:0] cfg_mask;
    logic [NUM_VARS-1:0] cfg_pol;
    logic                cfg_num_we;
    logic [CNT_W-1:0]    cfg_num;
    logic                cfg_err;
    logic                in_valid;
    logic                in_ready;
    logic [NUM_VARS-1:0] in_vec;
    logic                out_valid;
    logic                out_ready;
    logic                out_val;
    logic                busy;
`ifdef ESOP_MATCH_CNT_EN
    logic [CNT_W-1:0]    out_match_cnt;
`endif

    modport master (
        output cfg_we, cfg_addr, cfg_mask, cfg_pol, cfg_num_we, cfg_num,
        output in_valid, in_vec, out_ready,
`ifdef ESOP_MATCH_CNT_EN
        input  out_match_cnt,
`endif
        input  cfg_err, in_ready, out_valid, out_val, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_mask, cfg_pol, cfg_num_we, cfg_num,
        input  in_valid, in_vec, out_ready,
`ifdef ESOP_MATCH_CNT_EN
        output out_match_cnt,
`endif
        output cfg_err, in_ready, out_valid, out_val, busy
    );

endinterface

// File: rtl/esop_cube_sequencer_match.sv
// Single-cube match: every cared variable must equal its polarity bit.
module esop_cube_match
    import esop_pkg::*;
(
    input  cube_t               i_cube,
    input  logic [NUM_VARS-1:0] i_vec,
    output logic                o_hit_c
);

    assign o_hit_c = (((i_vec ^ i_cube.pol) & i_cube.mask) == '0);

endmodule

// File: rtl/esop_cube_sequencer.sv
// Cube-serial ESOP evaluator: one cube per cycle, XOR-accumulated hits.
// ESOP_MATCH_CNT_EN adds out_match_cnt (number of cubes hit).
module esop_cube_sequencer
    import esop_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    esop_cube_sequencer_if.slave  bus
);

    seq_state_e          r_state;
    seq_state_e          w_nxt_state;
    cube_t               r_mem [MAX_CUBES];
    logic [NUM_VARS-1:0] r_vec;
    logic [CNT_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_num;
    logic                r_acc;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_cfg_err;

    logic [CNT_W-1:0]    w_num_clamp;
    logic [CNT_W-1:0]    w_num_eff;
    logic                w_num_wr;
    logic                w_cube_wr;
    logic                w_cfg_err;
    logic                w_accept;
    logic                w_addr_ok;
    logic                w_last;
    logic                w_hit;
    cube_t               w_cube;

    // Address range check only exists when the capacity is not a power of two
    if (MAX_CUBES == (1 << CUBE_AW)) begin : g_addr_full
        assign w_addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign w_addr_ok = ({1'b0, bus.cfg_addr} < CNT_W'(MAX_CUBES));
    end

    assign w_num_clamp = (bus.cfg_num > CNT_W'(MAX_CUBES)) ? CNT_W'(MAX_CUBES) : bus.cfg_num;
    // A count write in the accept cycle governs that same vector
    assign w_num_eff   = (bus.cfg_num_we && (r_state == IDLE)) ? w_num_clamp : r_num;
    assign w_last      = (r_idx == (r_num - CNT_W'(1)));
    assign w_cube      = r_mem[r_idx[CUBE_AW-1:0]];

    esop_cube_match u_match (
        .i_cube  (w_cube),
        .i_vec   (r_vec),
        .o_hit_c (w_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_accept    = 1'b0;
        w_cube_wr   = 1'b0;
        w_num_wr    = 1'b0;
        w_cfg_err   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cube_wr = bus.cfg_we & w_addr_ok;
                w_num_wr  = bus.cfg_num_we;
                w_cfg_err = bus.cfg_we & ~w_addr_ok;
                w_accept  = bus.in_valid;
                if (bus.in_valid) begin
                    w_nxt_state = (w_num_eff != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                w_cfg_err = bus.cfg_we | bus.cfg_num_we;
                if (w_last) begin
                    w_nxt_state = DONE;
                end
            end
            DONE: begin
                w_cfg_err = bus.cfg_we | bus.cfg_num_we;
                if (bus.out_ready) begin
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Cube memory is deliberately not reset so programs survive rst
    always_ff @(posedge clk) begin
        if (w_cube_wr && !rst) begin
            r_mem[bus.cfg_addr] <= '{mask: bus.cfg_mask, pol: bus.cfg_pol};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num       <= '0;
            r_idx       <= '0;
            r_vec       <= '0;
            r_acc       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_in_ready  <= (w_nxt_state == IDLE);
            r_out_valid <= (w_nxt_state == DONE);
            r_busy      <= (w_nxt_state != IDLE);
            r_cfg_err   <= w_cfg_err;
            if (w_num_wr) begin
                r_num <= w_num_clamp;
            end
            if (w_accept) begin
                r_vec <= bus.in_vec;
                r_acc <= 1'b0;
                r_idx <= '0;
            end else if (r_state == RUN) begin
                r_acc <= r_acc ^ w_hit;
                r_idx <= r_idx + CNT_W'(1);
            end
        end
    end

`ifdef ESOP_MATCH_CNT_EN
    logic [CNT_W-1:0] r_match_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_cnt <= '0;
        end else if (w_accept) begin
            r_match_cnt <= '0;
        end else if (r_state == RUN) begin
            r_match_cnt <= r_match_cnt + CNT_W'(w_hit);
        end
    end

    assign bus.out_match_cnt = r_match_cnt;
`endif

    assign bus.cfg_err   = r_cfg_err;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_val   = r_acc;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_esop_cube_sequencer.sv
// Self-checking bench for esop_cube_sequencer against a cube-list model.
module tb_esop_cube_sequencer;
    import esop_pkg::*;

    logic clk = 1'b0;
    logic rst;
    esop_cube_sequencer_if bus_if ();

    esop_cube_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [NUM_VARS-1:0] m_mask [MAX_CUBES];
    logic [NUM_VARS-1:0] m_pol  [MAX_CUBES];
    int                  m_num;

    typedef struct {
        int                  num;
        logic [NUM_VARS-1:0] vec;
        logic                exp_val;
        int                  exp_lat;
    } vec_rec_t;

    vec_rec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Count of cubes whose every cared literal matches the vector
    function automatic int ref_hits(input logic [NUM_VARS-1:0] v);
        int h = 0;
        for (int c = 0; c < m_num; c++) begin
            bit ok = 1'b1;
            for (int b = 0; b < int'(NUM_VARS); b++) begin
                if (m_mask[c][b] && (v[b] != m_pol[c][b])) ok = 1'b0;
            end
            if (ok) h++;
        end
        return h;
    endfunction

    task automatic cfg_cube(input int addr, input logic [NUM_VARS-1:0] mask, input logic [NUM_VARS-1:0] pol);
        bus_if.cfg_we   = 1'b1;
        bus_if.cfg_addr = CUBE_AW'(addr);
        bus_if.cfg_mask = mask;
        bus_if.cfg_pol  = pol;
        m_mask[addr]    = mask;
        m_pol[addr]     = pol;
        tick();
        bus_if.cfg_we   = 1'b0;
    endtask

    task automatic cfg_n(input int n);
        bus_if.cfg_num_we = 1'b1;
        bus_if.cfg_num    = CNT_W'(n);
        m_num             = (n > int'(MAX_CUBES)) ? int'(MAX_CUBES) : n;
        tick();
        bus_if.cfg_num_we = 1'b0;
    endtask

    task automatic accept_vec(input logic [NUM_VARS-1:0] v);
        int w = 0;
        while (!bus_if.in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!bus_if.in_ready) chk("in_ready_wait", 32'(bus_if.in_ready), 32'd1);
        bus_if.in_vec     = v;
        bus_if.in_valid   = 1'b1;
        tick();
        bus_if.in_valid   = 1'b0;
        bus_if.cfg_we     = 1'b0;
        bus_if.cfg_num_we = 1'b0;
        chk("busy_after_accept", 32'(bus_if.busy), 32'd1);
    endtask

    task automatic finish_vec(input string nm, input logic exp_val, input int exp_lat,
                              input int exp_cnt, input int hold, input int start);
        int cyc = start;
        while (!bus_if.out_valid && cyc < 400) begin
            chk({nm, "_in_ready_run"}, 32'(bus_if.in_ready), 32'd0);
            tick();
            cyc++;
        end
        chk({nm, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({nm, "_val"}, 32'(bus_if.out_val), 32'(exp_val));
`ifdef ESOP_MATCH_CNT_EN
        chk({nm, "_cnt"}, 32'(bus_if.out_match_cnt), 32'(exp_cnt));
`else
        if (exp_cnt < 0) chk({nm, "_cnt_arg"}, 32'(exp_cnt), 32'd0);
`endif
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({nm, "_hold_valid"}, 32'(bus_if.out_valid), 32'd1);
            chk({nm, "_hold_val"}, 32'(bus_if.out_val), 32'(exp_val));
            chk({nm, "_hold_in_ready"}, 32'(bus_if.in_ready), 32'd0);
        end
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        chk({nm, "_post_valid"}, 32'(bus_if.out_valid), 32'd0);
        chk({nm, "_post_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    endtask

    task automatic run_vec(input string nm, input logic [NUM_VARS-1:0] v, input int hold);
        int h = ref_hits(v);
        accept_vec(v);
        finish_vec(nm, h[0], m_num + 1, h, hold, 1);
    endtask

    initial begin
        logic [NUM_VARS-1:0] v;
        int                  h;
        int                  seen;

        tbl[0] = '{num: 2, vec: 10'h1C0, exp_val: 1'b0, exp_lat: 3};
        tbl[1] = '{num: 2, vec: 10'h080, exp_val: 1'b1, exp_lat: 3};
        tbl[2] = '{num: 2, vec: 10'h140, exp_val: 1'b1, exp_lat: 3};
        tbl[3] = '{num: 1, vec: 10'h140, exp_val: 1'b1, exp_lat: 2};
        tbl[4] = '{num: 0, vec: 10'h3FF, exp_val: 1'b0, exp_lat: 1};
        tbl[5] = '{num: 0, vec: 10'h000, exp_val: 1'b0, exp_lat: 1};

        bus_if.cfg_we     = 1'b0;
        bus_if.cfg_addr   = '0;
        bus_if.cfg_mask   = '0;
        bus_if.cfg_pol    = '0;
        bus_if.cfg_num_we = 1'b0;
        bus_if.cfg_num    = '0;
        bus_if.in_valid   = 1'b0;
        bus_if.in_vec     = '0;
        bus_if.out_ready  = 1'b0;
        m_num = 0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_out_val",   32'(bus_if.out_val),   32'd0);
        chk("rst_busy",      32'(bus_if.busy),      32'd0);
        chk("rst_cfg_err",   32'(bus_if.cfg_err),   32'd0);
`ifdef ESOP_MATCH_CNT_EN
        chk("rst_cnt",       32'(bus_if.out_match_cnt), 32'd0);
`endif

        // Test-plan vectors: cube0 = x6&x8, cube1 = x7
        cfg_cube(0, 10'h140, 10'h140);
        cfg_cube(1, 10'h080, 10'h080);
        for (int i = 0; i < 6; i++) begin
            cfg_n(tbl[i].num);
            h = ref_hits(tbl[i].vec);
            accept_vec(tbl[i].vec);
            finish_vec($sformatf("tbl%0d", i), tbl[i].exp_val, tbl[i].exp_lat, h, 0, 1);
        end

        // Back-pressure: result held 5 cycles
        cfg_n(2);
        accept_vec(10'h080);
        finish_vec("hold5", 1'b1, 3, 1, 5, 1);

        // Cube and count write in the accept cycle apply to that vector
        bus_if.cfg_we     = 1'b1;
        bus_if.cfg_addr   = CUBE_AW'(2);
        bus_if.cfg_mask   = '0;
        bus_if.cfg_pol    = '0;
        m_mask[2]         = '0;
        m_pol[2]          = '0;
        bus_if.cfg_num_we = 1'b1;
        bus_if.cfg_num    = CNT_W'(3);
        m_num             = 3;
        accept_vec(10'h080);
        finish_vec("simul", 1'b0, 4, 2, 0, 1);

        // Writes during RUN are dropped with one cfg_err pulse
        for (int c = 0; c < 10; c++) cfg_cube(c, 10'($urandom & $urandom), 10'($urandom));
        cfg_n(10);
        v = 10'($urandom);
        h = ref_hits(v);
        accept_vec(v);
        tick();
        bus_if.cfg_we     = 1'b1;
        bus_if.cfg_addr   = '0;
        bus_if.cfg_mask   = ~m_mask[0];
        bus_if.cfg_pol    = ~m_pol[0];
        bus_if.cfg_num_we = 1'b1;
        bus_if.cfg_num    = CNT_W'(1);
        tick();
        bus_if.cfg_we     = 1'b0;
        bus_if.cfg_num_we = 1'b0;
        chk("cfg_err_pulse", 32'(bus_if.cfg_err), 32'd1);
        tick();
        chk("cfg_err_clear", 32'(bus_if.cfg_err), 32'd0);
        finish_vec("run_write", h[0], 11, h, 0, 4);
        v = ~v;
        run_vec("run_write_after", v, 0);

        // Reset on RUN cycle 2 of a 10-cube run
        v = 10'($urandom);
        accept_vec(v);
        tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        m_num = 0;
        chk("midrst_in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("midrst_busy",      32'(bus_if.busy),      32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_if.out_valid) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        cfg_n(10);
        run_vec("midrst_rerun", v, 0);

        // Randomised cube lists, counts and vectors against the model
        for (int c = 0; c < 16; c++) cfg_cube(c, 10'($urandom & $urandom), 10'($urandom));
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_cube(int'($urandom_range(0, 15)), 10'($urandom & $urandom), 10'($urandom));
            cfg_n(int'($urandom_range(0, 16)));
            run_vec($sformatf("rand%0d", t), 10'($urandom), int'($urandom_range(0, 2)));
        end

        // Full list of constant-1 cubes: count write clamps to capacity
        for (int c = 0; c < int'(MAX_CUBES); c++) cfg_cube(c, '0, 10'($urandom));
        cfg_n(200);
        accept_vec(10'($urandom));
        finish_vec("full128", 1'b0, 129, 128, 0, 1);
        cfg_n(127);
        accept_vec(10'($urandom));
        finish_vec("full127", 1'b1, 128, 127, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
